imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Pipelined, parametrised immediate-extension unit for the ARM datapath. It generates the immediate operand from the low 24 instruction bits for six encodings:
- zero-extended imm8 and imm12
- ARM rotated imm8, with shifter carry-out
- split halfword imm8
- U-bit signed imm12
- sign-extended, shifted branch offset

It sits between decode and execute as a two-stage valid/ready pipeline with flush, so the decoder can be stalled independently of this unit.

## Interface
Parameters:
- XLEN, 32: output width; must be ≥ 32. Results are formed at 32 bits, then zero- or sign-extended to XLEN as stated per mode.
- BR_SHIFT, 2: left shift applied to the branch offset (0..3).

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of both pipeline stages
- in_valid  input  1  Instr/ImmSrc are valid this cycle
- in_ready  output  1  unit accepts this cycle
- Instr  input  24  instruction bits [23:0]
- ImmSrc  input  3  extension mode
- out_valid  output  1  ExtImm/out_carry/out_carry_valid/out_err are valid
- out_ready  input  1  consumer takes the result this cycle
- ExtImm  output  XLEN  extended immediate
- out_carry  output  1  shifter carry-out (rotated mode only)
- out_carry_valid  output  1  out_carry is meaningful (rotated mode with rot ≠ 0)
- out_err  output  1  ImmSrc was not one of the defined modes

## Operation
Modes by ImmSrc:
- 000: {0, Instr[7:0]}, zero-extended.
- 001: {0, Instr[11:0]}, zero-extended.
- 010: Instr[23:0] sign-extended to XLEN, then shifted left by BR_SHIFT. Bits shifted past XLEN are dropped.
- 011: rotated imm8.
  - rot = Instr[11:8]; result32 = Instr[7:0] rotated right within 32 bits by 2·rot, then zero-extended to XLEN.
  - rot ≠ 0: out_carry = result32[31], out_carry_valid = 1.
  - rot = 0: out_carry = 0, out_carry_valid = 0.
- 100: {0, Instr[11:8], Instr[3:0]}, zero-extended.
- 101: m = Instr[11:0]. Instr[23] = 1 gives +m; Instr[23] = 0 gives −m in XLEN-bit two's complement. m = 0 gives 0 either way.
- 110, 111: ExtImm = 0, out_err = 1.
- out_err = 0 for every defined mode.
- out_carry = 0 and out_carry_valid = 0 in every mode except 011.

Pipeline stages:
- Stage A registers Instr, ImmSrc and a valid bit.
- Stage B registers the computed ExtImm, out_carry, out_carry_valid and out_err, plus out_valid.
- All outputs come directly from stage-B flops.

Advance and handshake rules:
- Stage B loads when B is empty or out_ready = 1.
- Stage A advances into B under the same condition.
- in_ready = !A_valid || (A advancing into B); combinational, no bubble.
- A transfer occurs on in_valid && in_ready. A transfer offered while flush = 1 is not captured.
- Stage B holds stable while out_valid = 1 and out_ready = 0.

## Timing
- Reset:
  - Both valid bits clear.
  - ExtImm = 0, out_carry = 0, out_carry_valid = 0, out_err = 0, out_valid = 0.
  - in_ready = 0 while reset is high; in_ready = 1 the first cycle after reset.
- Latency: input accepted at edge N gives out_valid = 1 after edge N+1.
- Throughput: one result per cycle while out_ready = 1.
- Full: with both stages valid and out_ready = 0, in_ready = 0.
- Full, then out_ready rises: in_ready = 1 in that same cycle, so a new accept and the B drain happen together.
- Flush:
  - On the edge where flush = 1, both valid bits clear.
  - Flush overrides a simultaneous accept and a simultaneous stage advance.
  - Data registers may hold stale values, but out_valid = 0 the next cycle.
- Reset has priority over flush. Reset mid-stream discards both stages; no result for those entries ever appears.
- No combinational path from out_ready to any output except in_ready.

## Test plan
- Reset, then mode 011 with Instr[11:0] = 0x4FF -> after 2 edges: ExtImm = 0xFF000000, out_carry = 1, out_carry_valid = 1, out_err = 0.
- Mode 010, Instr = 0xFFFFFE, BR_SHIFT = 2 -> ExtImm = 0xFFFFFFF8. Same with Instr = 0x000001 -> 0x00000004.
- Mode 101 with Instr[23] = 0, m = 0x004 -> 0xFFFFFFFC. Instr[23] = 1 -> 0x00000004. Mode 100 with Instr[11:8] = 0xA, Instr[3:0] = 0x5 -> 0x000000A5. Mode 011 with rot = 0, imm8 = 0x80 -> 0x00000080, out_carry_valid = 0.
- Back-to-back stream of 8 inputs, out_ready = 1 -> 8 results in order on consecutive cycles. Then hold out_ready = 0 for 3 cycles -> in_ready = 0 once 2 entries are held, ExtImm stable. Release -> in-order drain with nothing lost or duplicated.
- Flush asserted with both stages full and in_valid = 1 -> next cycle out_valid = 0, no entry captured. Separately, reset asserted mid-stream -> all outputs 0 and out_valid = 0.
- ImmSrc = 111 -> ExtImm = 0, out_err = 1. XLEN = 64 build: mode 010 with Instr = 0x800000 -> 0xFFFFFFFFFE000000.

Source files
------------

// File: rtl/imm_extend_pipe_if.sv
// Handshake and data bundle between decode, the immediate-extension pipe and execute.
// The pipe itself uses the slave view; the driving/consuming side uses master.
interface imm_extend_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [23:0]     Instr;
    logic [2:0]      ImmSrc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ExtImm;
    logic            out_carry;
    logic            out_carry_valid;
    logic            out_err;

    modport slave (
        input  in_valid, Instr, ImmSrc, out_ready,
        output in_ready, out_valid, ExtImm, out_carry, out_carry_valid, out_err
    );

    modport master (
        output in_valid, Instr, ImmSrc, out_ready,
        input  in_ready, out_valid, ExtImm, out_carry, out_carry_valid, out_err
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate-extension unit: stage A holds the raw instruction
// bits, stage B holds the extended immediate. All outputs are driven from stage-B flops.
module imm_extend_pipe #(
    parameter int XLEN     = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    imm_extend_pipe_if.slave  bus
);
    localparam logic [2:0] MODE_IMM8   = 3'b000;
    localparam logic [2:0] MODE_IMM12  = 3'b001;
    localparam logic [2:0] MODE_BRANCH = 3'b010;
    localparam logic [2:0] MODE_ROT    = 3'b011;
    localparam logic [2:0] MODE_HALF   = 3'b100;
    localparam logic [2:0] MODE_UIMM   = 3'b101;

    logic            aValid_q, aValid_d;
    logic [23:0]     aInstr_q, aInstr_d;
    logic [2:0]      aSrc_q, aSrc_d;

    logic            bValid_q, bValid_d;
    logic [XLEN-1:0] bExt_q, bExt_d;
    logic            bCarry_q, bCarry_d;
    logic            bCarryValid_q, bCarryValid_d;
    logic            bErr_q, bErr_d;

    logic            bLoad;
    logic            inReady;
    logic            accept;

    logic [XLEN-1:0] compExt;
    logic            compCarry;
    logic            compCarryValid;
    logic            compErr;

    logic [63:0]     rotPair;
    logic [4:0]      rotAmt;
    logic [31:0]     rot32;
    logic [XLEN-1:0] brSext;
    logic [XLEN-1:0] uMag;

    // B refills whenever it is empty or being drained; A moves along with it.
    assign bLoad   = !bValid_q || bus.out_ready;
    assign inReady = !reset && (!aValid_q || bLoad);
    assign accept  = bus.in_valid && inReady && !flush;

    // Right-rotate by 2*rot is the low word of the doubled operand shifted right.
    assign rotPair = {24'd0, aInstr_q[7:0], 24'd0, aInstr_q[7:0]};
    assign rotAmt  = {aInstr_q[11:8], 1'b0};
    assign rot32   = 32'(rotPair >> rotAmt);
    assign brSext  = {{(XLEN-24){aInstr_q[23]}}, aInstr_q};
    assign uMag    = {{(XLEN-12){1'b0}}, aInstr_q[11:0]};

    always_comb begin
        compExt        = '0;
        compCarry      = 1'b0;
        compCarryValid = 1'b0;
        compErr        = 1'b0;
        case (aSrc_q)
            MODE_IMM8:   compExt = {{(XLEN-8){1'b0}}, aInstr_q[7:0]};
            MODE_IMM12:  compExt = {{(XLEN-12){1'b0}}, aInstr_q[11:0]};
            MODE_BRANCH: compExt = brSext << BR_SHIFT;
            MODE_ROT: begin
                compExt = {{(XLEN-32){1'b0}}, rot32};
                if (aInstr_q[11:8] != 4'd0) begin
                    compCarry      = rot32[31];
                    compCarryValid = 1'b1;
                end
            end
            MODE_HALF:   compExt = {{(XLEN-8){1'b0}}, aInstr_q[11:8], aInstr_q[3:0]};
            MODE_UIMM:   compExt = aInstr_q[23] ? uMag : (~uMag + {{(XLEN-1){1'b0}}, 1'b1});
            default:     compErr = 1'b1;
        endcase
    end

    // Flush clears both valid bits and beats any simultaneous accept or advance.
    always_comb begin
        aInstr_d      = aInstr_q;
        aSrc_d        = aSrc_q;
        bExt_d        = bExt_q;
        bCarry_d      = bCarry_q;
        bCarryValid_d = bCarryValid_q;
        bErr_d        = bErr_q;

        if (flush) begin
            aValid_d = 1'b0;
        end else if (accept) begin
            aValid_d = 1'b1;
        end else if (bLoad) begin
            aValid_d = 1'b0;
        end else begin
            aValid_d = aValid_q;
        end

        if (accept) begin
            aInstr_d = bus.Instr;
            aSrc_d   = bus.ImmSrc;
        end

        if (flush) begin
            bValid_d = 1'b0;
        end else if (bLoad) begin
            bValid_d = aValid_q;
        end else begin
            bValid_d = bValid_q;
        end

        if (bLoad && aValid_q && !flush) begin
            bExt_d        = compExt;
            bCarry_d      = compCarry;
            bCarryValid_d = compCarryValid;
            bErr_d        = compErr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aValid_q      <= 1'b0;
            aInstr_q      <= '0;
            aSrc_q        <= '0;
            bValid_q      <= 1'b0;
            bExt_q        <= '0;
            bCarry_q      <= 1'b0;
            bCarryValid_q <= 1'b0;
            bErr_q        <= 1'b0;
        end else begin
            aValid_q      <= aValid_d;
            aInstr_q      <= aInstr_d;
            aSrc_q        <= aSrc_d;
            bValid_q      <= bValid_d;
            bExt_q        <= bExt_d;
            bCarry_q      <= bCarry_d;
            bCarryValid_q <= bCarryValid_d;
            bErr_q        <= bErr_d;
        end
    end

    assign bus.in_ready        = inReady;
    assign bus.out_valid       = bValid_q;
    assign bus.ExtImm          = bExt_q;
    assign bus.out_carry       = bCarry_q;
    assign bus.out_carry_valid = bCarryValid_q;
    assign bus.out_err         = bErr_q;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized and directed bench for imm_extend_pipe; a queue-based reference model
// predicts every visible result and the handshake, checked once per cycle.
module tb_imm_extend_pipe;
    localparam int BRS = 2;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    imm_extend_pipe_if #(.XLEN(32)) bus ();
    imm_extend_pipe_if #(.XLEN(64)) bus64 ();

    imm_extend_pipe #(.XLEN(32), .BR_SHIFT(BRS)) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus)
    );
    imm_extend_pipe #(.XLEN(64), .BR_SHIFT(BRS)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ext;
        logic        carry;
        logic        cv;
        logic        err;
        logic        inB;
    } entry_t;

    entry_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the field values, no bit-level datapath.
    function automatic entry_t model(input logic [23:0] instr, input logic [2:0] src);
        entry_t e;
        longint v;
        int unsigned iv;
        int rs;
        iv = 32'(instr);
        e.ext = 32'd0; e.carry = 1'b0; e.cv = 1'b0; e.err = 1'b0; e.inB = 1'b0;
        case (src)
            3'd0: e.ext = iv % 256;
            3'd1: e.ext = iv % 4096;
            3'd2: begin
                v = longint'(iv);
                if (iv >= 32'h800000) v = v - 64'd16777216;
                v = v * (64'd1 << BRS);
                e.ext = v[31:0];
            end
            3'd3: begin
                v = longint'(iv % 256);
                rs = 2 * int'((iv / 256) % 16);
                repeat (rs) v = ((v % 2) * 64'h80000000) + (v / 2);
                e.ext = v[31:0];
                if (rs != 0) begin
                    e.cv = 1'b1;
                    e.carry = e.ext[31];
                end
            end
            3'd4: e.ext = ((iv / 256) % 16) * 16 + (iv % 16);
            3'd5: begin
                if (instr[23]) e.ext = iv % 4096;
                else begin
                    v = 64'h1_0000_0000 - longint'(iv % 4096);
                    e.ext = v[31:0];
                end
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Compare every cycle, then advance the model for the coming edge.
    always @(negedge clk) begin
        logic expValid, expReady, take, acc;
        expValid = (q.size() > 0) && q[0].inB;
        expReady = !reset && !(q.size() == 2 && !bus.out_ready);
        chk("out_valid", 64'(bus.out_valid), 64'(expValid));
        chk("in_ready", 64'(bus.in_ready), 64'(expReady));
        if (expValid) begin
            chk("ExtImm", 64'(bus.ExtImm), 64'(q[0].ext));
            chk("out_carry", 64'(bus.out_carry), 64'(q[0].carry));
            chk("out_carry_valid", 64'(bus.out_carry_valid), 64'(q[0].cv));
            chk("out_err", 64'(bus.out_err), 64'(q[0].err));
        end
        take = expValid && bus.out_ready;
        acc  = bus.in_valid && expReady && !flush && !reset;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (take) void'(q.pop_front());
            if (q.size() > 0 && !q[0].inB) q[0].inB = 1'b1;
            if (acc) q.push_back(model(bus.Instr, bus.ImmSrc));
        end
    end

    task automatic applyStimulus(input logic [23:0] instr, input logic [2:0] src);
        logic accepted;
        int n;
        bus.in_valid = 1'b1;
        bus.Instr    = instr;
        bus.ImmSrc   = src;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 20) begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!accepted) chk("accept_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] ext, input logic c,
                               input logic cv, input logic err);
        chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({name, "_ext"}, 64'(bus.ExtImm), 64'(ext));
        chk({name, "_carry"}, 64'(bus.out_carry), 64'(c));
        chk({name, "_cv"}, 64'(bus.out_carry_valid), 64'(cv));
        chk({name, "_err"}, 64'(bus.out_err), 64'(err));
    endtask

    task automatic directed(input string name, input logic [23:0] instr, input logic [2:0] src,
                            input logic [31:0] ext, input logic c, input logic cv, input logic err);
        applyStimulus(instr, src);
        @(posedge clk);
        #1;
        checkOutput(name, ext, c, cv, err);
    endtask

    initial begin
        int cnt;
        logic [31:0] held;
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0; bus.Instr = '0; bus.ImmSrc = '0; bus.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.Instr = '0; bus64.ImmSrc = '0; bus64.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_ext", 64'(bus.ExtImm), 64'd0);
        chk("rst_flags", {61'd0, bus.out_carry, bus.out_carry_valid, bus.out_err}, 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        directed("rot4ff", 24'h0004FF, 3'd3, 32'hFF000000, 1'b1, 1'b1, 1'b0);
        directed("br_neg", 24'hFFFFFE, 3'd2, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0);
        directed("br_pos", 24'h000001, 3'd2, 32'h00000004, 1'b0, 1'b0, 1'b0);
        directed("u_neg", 24'h000004, 3'd5, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0);
        directed("u_pos", 24'h800004, 3'd5, 32'h00000004, 1'b0, 1'b0, 1'b0);
        directed("u_zero", 24'h000000, 3'd5, 32'h00000000, 1'b0, 1'b0, 1'b0);
        directed("half", 24'h000A05, 3'd4, 32'h000000A5, 1'b0, 1'b0, 1'b0);
        directed("rot0", 24'h000080, 3'd3, 32'h00000080, 1'b0, 1'b0, 1'b0);
        directed("imm8", 24'hABCDEF, 3'd0, 32'h000000EF, 1'b0, 1'b0, 1'b0);
        directed("imm12", 24'hABCDEF, 3'd1, 32'h00000DEF, 1'b0, 1'b0, 1'b0);
        directed("bad111", 24'h123456, 3'd7, 32'h00000000, 1'b0, 1'b0, 1'b1);

        bus64.in_valid = 1'b1; bus64.Instr = 24'h800000; bus64.ImmSrc = 3'd2;
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("x64_valid", 64'(bus64.out_valid), 64'd1);
        chk("x64_branch", bus64.ExtImm, 64'hFFFFFFFFFE000000);

        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.Instr = 24'($urandom);
            bus.ImmSrc = 3'($urandom_range(0, 5));
            @(posedge clk);
            #1;
            if (bus.out_valid) cnt++;
        end
        bus.in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) cnt++;
        end
        chk("b2b_count", 64'(cnt), 64'd8);

        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.Instr = 24'($urandom);
            bus.ImmSrc = 3'($urandom_range(0, 5));
            @(posedge clk);
            #1;
        end
        bus.Instr = 24'($urandom);
        held = bus.ExtImm;
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_ext", 64'(bus.ExtImm), 64'(held));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        applyStimulus(24'h000011, 3'd0);
        applyStimulus(24'h000022, 3'd0);
        bus.in_valid = 1'b1; bus.Instr = 24'h000033; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("flush_no_capture", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.Instr = 24'($urandom);
            bus.ImmSrc = 3'd3;
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_ext", 64'(bus.ExtImm), 64'd0);
        chk("midrst_flags", {61'd0, bus.out_carry, bus.out_carry_valid, bus.out_err}, 64'd0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 3) != 0);
            bus.Instr     = 24'($urandom);
            bus.ImmSrc    = 3'($urandom_range(0, 7));
            bus.out_ready = 1'($urandom_range(0, 9) < 7);
            flush         = 1'($urandom_range(0, 49) == 0);
            reset         = 1'($urandom_range(0, 299) == 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; flush = 1'b0; reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
